mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single-port 4 KB data SRAM (1024 x 32-bit words, byte write enables) between two requesters: the fetch unit (read-only) and the execute stage (loads/stores).
- Sits between the fetch/exec stages and the SRAM macro.
- Grants one requester per cycle. Exec has priority, with a starvation limiter that guarantees fetch progress.
- Read data returns one cycle after grant, tagged back to the owner.

Parameters:
- ADDR_W, 10, word address width of the SRAM.
- DATA_W, 32, data width.
- WEN_W, 4, byte-enable width (DATA_W/8).
- STARVE_LIMIT, 4, maximum consecutive exec grants while fetch is waiting (legal range 1..15).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- f_req  in  1  fetch read request; held with f_addr stable until f_gnt.
- f_addr  in  ADDR_W  fetch word address.
- f_gnt  out  1  fetch request accepted this cycle.
- f_rvalid  out  1  f_rdata valid (one cycle after f_gnt).
- f_rdata  out  DATA_W  fetch read data.
- e_req  in  1  exec request; e_addr/e_wen/e_wd held stable until e_gnt.
- e_addr  in  ADDR_W  exec word address.
- e_wen  in  WEN_W  byte write enables; 0 = read.
- e_wd  in  DATA_W  exec write data.
- e_gnt  out  1  exec request accepted this cycle.
- e_rvalid  out  1  e_rdata valid (one cycle after a read e_gnt).
- e_rdata  out  DATA_W  exec read data.
- sram_a  out  ADDR_W  SRAM address.
- sram_wen  out  WEN_W  SRAM byte write enables.
- sram_wd  out  DATA_W  SRAM write data.
- sram_en  out  1  SRAM access strobe (drives the SRAM m_inp_rdy).
- sram_rd  in  DATA_W  SRAM read data, valid the cycle after access.
- busy  out  1  an SRAM access is issued this cycle (= sram_en).

Behaviour:
- Clock/reset: one clock, clk. Reset is asynchronous, active-low on rst_n.
- Reset values:
  - f_rvalid = e_rvalid = 0.
  - owner register = NONE.
  - starvation counter = 0.
  - While rst_n is low, f_gnt = e_gnt = sram_en = busy = 0 and sram_wen = 0.
- Arbitration (combinational, same cycle as request):
  - Neither request: no grant. sram_en = 0, sram_wen = 0, sram_a/sram_wd don't-care.
  - Only one request: that requester is granted.
  - Both requesting: exec wins unless the counter equals STARVE_LIMIT, in which case fetch wins.
- Granted requester's signals drive the SRAM ports with sram_en = 1:
  - Exec grant: sram_wen = e_wen, sram_wd = e_wd.
  - Fetch grant: sram_wen is forced to 0.
- Starvation counter (saturating at STARVE_LIMIT), updated on the clock edge:
  - Increment on an exec grant while f_req = 1.
  - Clear on a fetch grant or when f_req = 0.
- Read pipeline:
  - A granted read (fetch, or exec with e_wen = 0) sets the owner register (FETCH/EXEC) on the clock edge; otherwise owner = NONE.
  - Next cycle: the owner's rvalid = 1 and its rdata = sram_rd. The other rvalid = 0.
  - rdata of a non-owner is held at its last value (no X propagation to the requester).
- Writes: e_gnt only; no e_rvalid. A write completes in the granted cycle.
- Throughput: one grant per cycle, back-to-back, with no bubble. A read grant in cycle t and a new grant in cycle t+1 overlap legally.
- Requester obligations: a request not granted must be held. The arbiter keeps no request queue; a dropped request is simply lost.
- Write followed by read of the same address in the next cycle returns the new data (SRAM write-first on the granted edge).
- Reset mid-operation: a pending rvalid is cancelled and the owner and counter are cleared. The requester must re-issue after reset.
- Latency:
  - Grant: 0 cycles from request when uncontested.
  - Read data: 1 cycle after grant.
  - Worst-case fetch wait under continuous exec traffic: STARVE_LIMIT cycles.

Test Plan:
- Lone fetch: f_req = 1, f_addr = 0x010, SRAM[0x010] = 0xDEADBEEF -> f_gnt same cycle, sram_wen = 0, f_rvalid = 1 with f_rdata = 0xDEADBEEF next cycle, e_rvalid = 0.
- Exec byte write then read: e_wen = 4'b0001, e_addr = 0x020, e_wd = 0x000000AB; next cycle e_wen = 0, same address -> e_gnt both cycles, e_rvalid only after the read, e_rdata[7:0] = 0xAB.
- Contention: f_req and e_req held high continuously, exec reads, STARVE_LIMIT = 4 -> grant sequence E,E,E,E,F,E,E,E,E,F.
- Back-to-back interleaving: fetch read 0x001, then exec read 0x002 in consecutive cycles -> f_rvalid in cycle t+1 and e_rvalid in t+2, each with the correct data and no cross-delivery.
- Reset mid-read: rst_n falls in the cycle after an f_gnt -> f_rvalid = 0 immediately; after rst_n rises, owner = NONE and counter = 0, so a fresh contention sequence starts with four exec grants.
- Idle: no requests for 10 cycles -> sram_en = 0, sram_wen = 0, busy = 0, both rvalid = 0 throughout.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the single-port data SRAM: exec has priority, fetch is starvation-limited.
// Grant is combinational in the request cycle; read data is returned and tagged to its owner one cycle later.
module mem_arbiter #(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 32,
  parameter int WEN_W        = DATA_W / 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              e_req,
  input  logic [ADDR_W-1:0] e_addr,
  input  logic [WEN_W-1:0]  e_wen,
  input  logic [DATA_W-1:0] e_wd,
  output logic              e_gnt,
  output logic              e_rvalid,
  output logic [DATA_W-1:0] e_rdata,
  output logic [ADDR_W-1:0] sram_a,
  output logic [WEN_W-1:0]  sram_wen,
  output logic [DATA_W-1:0] sram_wd,
  output logic              sram_en,
  input  logic [DATA_W-1:0] sram_rd,
  output logic              busy
);

  typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_EXEC} owner_t;

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  owner_t            r_owner;
  logic [CNT_W-1:0]  r_starve;
  logic [DATA_W-1:0] r_f_rdata;
  logic [DATA_W-1:0] r_e_rdata;
  logic              w_f_win;
  logic              w_e_win;

  // Gated by rst_n so nothing reaches the SRAM while reset is held.
  always_comb begin
    w_f_win = 1'b0;
    w_e_win = 1'b0;
    if (rst_n) begin
      if (f_req && e_req) begin
        w_f_win = (r_starve == LIMIT);
        w_e_win = (r_starve != LIMIT);
      end else begin
        w_f_win = f_req;
        w_e_win = e_req;
      end
    end
  end

  assign f_gnt    = w_f_win;
  assign e_gnt    = w_e_win;
  assign sram_en  = w_f_win | w_e_win;
  assign busy     = sram_en;
  assign sram_a   = w_f_win ? f_addr : e_addr;
  assign sram_wen = w_e_win ? e_wen : '0;
  assign sram_wd  = e_wd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner   <= OWN_NONE;
      r_starve  <= '0;
      r_f_rdata <= '0;
      r_e_rdata <= '0;
    end else begin
      if (w_f_win)
        r_owner <= OWN_FETCH;
      else if (w_e_win && (e_wen == '0))
        r_owner <= OWN_EXEC;
      else
        r_owner <= OWN_NONE;

      if (w_f_win || !f_req)
        r_starve <= '0;
      else if (w_e_win && (r_starve != LIMIT))
        r_starve <= r_starve + 1'b1;

      // Hold the last delivered word so non-owners never see SRAM garbage.
      if (r_owner == OWN_FETCH) r_f_rdata <= sram_rd;
      if (r_owner == OWN_EXEC)  r_e_rdata <= sram_rd;
    end
  end

  assign f_rvalid = (r_owner == OWN_FETCH);
  assign e_rvalid = (r_owner == OWN_EXEC);
  assign f_rdata  = f_rvalid ? sram_rd : r_f_rdata;
  assign e_rdata  = e_rvalid ? sram_rd : r_e_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic against a behavioural SRAM and arbiter model.
module tb_mem_arbiter;

  localparam int STARVE = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        f_req, e_req;
  logic [9:0]  f_addr, e_addr;
  logic [3:0]  e_wen;
  logic [31:0] e_wd;
  logic        f_gnt, e_gnt, f_rvalid, e_rvalid;
  logic [31:0] f_rdata, e_rdata;
  logic [9:0]  sram_a;
  logic [3:0]  sram_wen;
  logic [31:0] sram_wd;
  logic        sram_en, busy;
  logic [31:0] sram_rd;

  logic [31:0] mem     [1024];
  logic [31:0] ref_mem [1024];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(10), .DATA_W(32), .WEN_W(4), .STARVE_LIMIT(STARVE)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .e_req(e_req), .e_addr(e_addr), .e_wen(e_wen), .e_wd(e_wd), .e_gnt(e_gnt),
    .e_rvalid(e_rvalid), .e_rdata(e_rdata),
    .sram_a(sram_a), .sram_wen(sram_wen), .sram_wd(sram_wd), .sram_en(sram_en),
    .sram_rd(sram_rd), .busy(busy)
  );

  // Behavioural single-port SRAM: byte writes land on the edge, reads return the next cycle.
  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_wen == 4'h0)
        sram_rd <= mem[sram_a];
      else
        for (int b = 0; b < 4; b++)
          if (sram_wen[b]) mem[sram_a][8*b +: 8] = sram_wd[8*b +: 8];
    end
  end

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    f_req = 1'b0; e_req = 1'b0;
    f_addr = '0; e_addr = '0; e_wen = '0; e_wd = '0;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[10'h010] = 32'hDEADBEEF;
    mem[10'h020] = 32'h11223344;
    mem[10'h001] = 32'hA5A50001;
    mem[10'h002] = 32'h5A5A0002;
    rst_n = 1'b0;
    f_req = 1'b1; e_req = 1'b1; f_addr = 10'h3; e_addr = 10'h4; e_wen = 4'hF; e_wd = '1;
    #3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({f_gnt, e_gnt, sram_en, busy, sram_wen, f_rvalid, e_rvalid} !== 10'b0) begin
        n_fail++;
        $display("FAIL reset_outputs: got gnt=%b%b en=%b busy=%b wen=%h rv=%b%b required all zero",
                 f_gnt, e_gnt, sram_en, busy, sram_wen, f_rvalid, e_rvalid);
      end
    end
    idle_inputs();
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_lone_fetch;
    f_req = 1'b1; f_addr = 10'h010;
    @(negedge clk);
    n_checks++;
    if (f_gnt !== 1'b1 || e_gnt !== 1'b0 || sram_en !== 1'b1 || sram_wen !== 4'h0 || sram_a !== 10'h010) begin
      n_fail++;
      $display("FAIL lone_fetch_grant: got fg=%b eg=%b en=%b wen=%h a=%h required 1 0 1 0 010",
               f_gnt, e_gnt, sram_en, sram_wen, sram_a);
    end
    next_cycle();
    f_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (f_rvalid !== 1'b1 || f_rdata !== 32'hDEADBEEF || e_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL lone_fetch_data: got frv=%b fd=%h erv=%b required 1 deadbeef 0", f_rvalid, f_rdata, e_rvalid);
    end
    next_cycle();
  endtask

  task automatic test_exec_write_read;
    e_req = 1'b1; e_addr = 10'h020; e_wen = 4'b0001; e_wd = 32'h000000AB;
    @(negedge clk);
    n_checks++;
    if (e_gnt !== 1'b1 || sram_wen !== 4'b0001 || sram_wd !== 32'h000000AB || sram_a !== 10'h020) begin
      n_fail++;
      $display("FAIL exec_write_grant: got eg=%b wen=%b wd=%h a=%h required 1 0001 000000ab 020",
               e_gnt, sram_wen, sram_wd, sram_a);
    end
    next_cycle();
    e_wen = 4'h0;
    @(negedge clk);
    n_checks++;
    if (e_gnt !== 1'b1 || e_rvalid !== 1'b0 || sram_wen !== 4'h0) begin
      n_fail++;
      $display("FAIL exec_read_grant: got eg=%b erv=%b wen=%h required 1 0 0", e_gnt, e_rvalid, sram_wen);
    end
    next_cycle();
    e_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (e_rvalid !== 1'b1 || e_rdata[7:0] !== 8'hAB || e_rdata !== 32'h112233AB || f_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL exec_read_data: got erv=%b ed=%h frv=%b required 1 112233ab 0", e_rvalid, e_rdata, f_rvalid);
    end
    next_cycle();
  endtask

  task automatic test_contention;
    // Fetch wins exactly once every STARVE+1 cycles under saturated exec traffic.
    f_req = 1'b1; f_addr = 10'h5; e_req = 1'b1; e_addr = 10'h6; e_wen = 4'h0;
    for (int i = 0; i < 10; i++) begin
      logic exp_f;
      exp_f = ((i % (STARVE + 1)) == STARVE);
      @(negedge clk);
      n_checks++;
      if (f_gnt !== exp_f || e_gnt !== !exp_f) begin
        n_fail++;
        $display("FAIL contention_cycle%0d: got fg=%b eg=%b required fg=%b eg=%b", i, f_gnt, e_gnt, exp_f, !exp_f);
      end
      next_cycle();
    end
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_back_to_back;
    f_req = 1'b1; f_addr = 10'h001;
    @(negedge clk);
    n_checks++;
    if (f_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_fetch_grant: got %b required 1", f_gnt);
    end
    next_cycle();
    f_req = 1'b0; e_req = 1'b1; e_addr = 10'h002; e_wen = 4'h0;
    @(negedge clk);
    n_checks++;
    if (e_gnt !== 1'b1 || f_rvalid !== 1'b1 || f_rdata !== 32'hA5A50001 || e_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_t1: got eg=%b frv=%b fd=%h erv=%b required 1 1 a5a50001 0", e_gnt, f_rvalid, f_rdata, e_rvalid);
    end
    next_cycle();
    e_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (e_rvalid !== 1'b1 || e_rdata !== 32'h5A5A0002 || f_rvalid !== 1'b0 || f_rdata !== 32'hA5A50001) begin
      n_fail++;
      $display("FAIL b2b_t2: got erv=%b ed=%h frv=%b fd=%h required 1 5a5a0002 0 a5a50001",
               e_rvalid, e_rdata, f_rvalid, f_rdata);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid_read;
    // Build up the starvation count, then take a fetch read and reset in its data cycle.
    f_req = 1'b1; f_addr = 10'h010; e_req = 1'b1; e_addr = 10'h7; e_wen = 4'h0;
    for (int i = 0; i < 3; i++) next_cycle();
    e_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (f_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_fgnt: got %b required 1", f_gnt);
    end
    next_cycle();
    f_req = 1'b0;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (f_rvalid !== 1'b0 || e_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_rvalid: got frv=%b erv=%b required 0 0", f_rvalid, e_rvalid);
    end
    next_cycle();
    rst_n = 1'b1;
    f_req = 1'b1; e_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      logic exp_f;
      exp_f = (i == STARVE);
      @(negedge clk);
      n_checks++;
      if (f_gnt !== exp_f || e_gnt !== !exp_f || f_rvalid !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_mid_seq%0d: got fg=%b eg=%b frv=%b required fg=%b", i, f_gnt, e_gnt, f_rvalid, exp_f);
      end
      next_cycle();
    end
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_idle;
    idle_inputs();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if ({sram_en, busy, sram_wen, f_rvalid, e_rvalid, f_gnt, e_gnt} !== 10'b0) begin
        n_fail++;
        $display("FAIL idle_cycle%0d: got en=%b busy=%b wen=%h rv=%b%b gnt=%b%b required all zero",
                 i, sram_en, busy, sram_wen, f_rvalid, e_rvalid, f_gnt, e_gnt);
      end
      next_cycle();
    end
  endtask

  task automatic test_random;
    int streak;
    logic gf, ge, exp_fv, exp_ev;
    logic [31:0] exp_fd, exp_ed, last_fd, last_ed;
    idle_inputs();
    rst_n = 1'b0;
    next_cycle();
    for (int i = 0; i < 1024; i++) ref_mem[i] = mem[i];
    rst_n = 1'b1;
    next_cycle();
    streak = 0; gf = 0; ge = 0; exp_fv = 0; exp_ev = 0;
    exp_fd = '0; exp_ed = '0; last_fd = '0; last_ed = '0;
    for (int c = 0; c < 400; c++) begin
      if (gf) f_req = 1'b0;
      if (ge) e_req = 1'b0;
      if (!f_req && $urandom_range(0, 2) != 0) begin
        f_req = 1'b1; f_addr = 10'($urandom_range(0, 31));
      end
      if (!e_req && $urandom_range(0, 3) != 0) begin
        e_req = 1'b1; e_addr = 10'($urandom_range(0, 31));
        e_wen = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
        e_wd = $urandom;
      end
      @(negedge clk);
      gf = f_req && (!e_req || streak == STARVE);
      ge = e_req && !gf;
      n_checks++;
      if (f_gnt !== gf || e_gnt !== ge || sram_en !== (gf | ge) || busy !== (gf | ge)) begin
        n_fail++;
        $display("FAIL rand_grant c%0d: got fg=%b eg=%b en=%b required fg=%b eg=%b", c, f_gnt, e_gnt, sram_en, gf, ge);
      end
      n_checks++;
      if (sram_wen !== (ge ? e_wen : 4'h0) || (gf && sram_a !== f_addr) || (ge && sram_a !== e_addr)) begin
        n_fail++;
        $display("FAIL rand_sram c%0d: got a=%h wen=%h", c, sram_a, sram_wen);
      end
      n_checks++;
      if (f_rvalid !== exp_fv || f_rdata !== (exp_fv ? exp_fd : last_fd)) begin
        n_fail++;
        $display("FAIL rand_fetch_rd c%0d: got rv=%b d=%h required rv=%b d=%h",
                 c, f_rvalid, f_rdata, exp_fv, exp_fv ? exp_fd : last_fd);
      end
      n_checks++;
      if (e_rvalid !== exp_ev || e_rdata !== (exp_ev ? exp_ed : last_ed)) begin
        n_fail++;
        $display("FAIL rand_exec_rd c%0d: got rv=%b d=%h required rv=%b d=%h",
                 c, e_rvalid, e_rdata, exp_ev, exp_ev ? exp_ed : last_ed);
      end
      if (exp_fv) last_fd = exp_fd;
      if (exp_ev) last_ed = exp_ed;
      exp_fv = gf;
      exp_ev = ge && (e_wen == 4'h0);
      if (gf) exp_fd = ref_mem[f_addr];
      if (exp_ev) exp_ed = ref_mem[e_addr];
      if (ge && e_wen != 4'h0)
        for (int b = 0; b < 4; b++)
          if (e_wen[b]) ref_mem[e_addr][8*b +: 8] = e_wd[8*b +: 8];
      if (gf || !f_req) streak = 0;
      else if (ge && streak < STARVE) streak++;
      next_cycle();
    end
    idle_inputs();
    next_cycle();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_lone_fetch();
    test_exec_write_read();
    test_contention();
    test_back_to_back();
    test_reset_mid_read();
    test_idle();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
